// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode constants and parameter legality checks for mod_counter
`ifndef COUNTER_PKG_SV
`define COUNTER_PKG_SV

// Parameter legality checks, evaluated at elaboration by the modules that take these parameters.
`define COUNTER_WIDTH_OK(w)        (counter_pkg::width_ok(w))
`define COUNTER_MOD_MAX_OK(m, w)   (counter_pkg::mod_max_ok(m, w))
`define COUNTER_PRESCALE_OK(p)     (counter_pkg::prescale_ok(p))

package counter_pkg;

    // SAT input encoding
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // DIR input encoding
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // Supported parameter ranges
    localparam int unsigned WIDTH_MIN    = 2;
    localparam int unsigned WIDTH_MAX    = 32;
    localparam int unsigned PRESCALE_MAX = 65535;

    function automatic bit width_ok(input int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

    // MOD_MAX must be non-zero and representable in WIDTH bits.
    function automatic bit mod_max_ok(input longint unsigned m, input int unsigned w);
        return (m >= 64'd1) && (m <= ((64'd1 << w) - 64'd1));
    endfunction

    function automatic bit prescale_ok(input int unsigned p);
        return (p >= 1) && (p <= PRESCALE_MAX);
    endfunction

    // Phase register width; a divide-by-one prescaler still keeps a single constant bit.
    function automatic int unsigned prescale_width(input int unsigned p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

`endif

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides qualified enable cycles down to count steps
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic Reset,
    input  logic EN,
    input  logic CLR,
    output logic tick
);

    localparam int unsigned     PW   = prescale_width(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    generate
        if (!`COUNTER_PRESCALE_OK(PRESCALE)) begin : g_bad_prescale
            $error("tick_prescaler: PRESCALE must be in 1..65535");
        end
    endgenerate

    // Phase of the current prescale window. With PRESCALE=1, LAST is 0 and the
    // register is stuck at zero, so tick collapses to EN.
    logic [PW-1:0] phase;

    // Advance on qualified EN, restart the window on the last phase; CLR and Reset discard a partial window.
    always_ff @(posedge clk) begin
        if (Reset || CLR) begin
            phase <= '0;
        end else if (EN) begin
            if (phase == LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

    // The step fires on the edge of the PRESCALE-th qualified EN.
    assign tick = EN && (phase == LAST);

endmodule

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - up/down modulo counter with prescaler, load, wrap/saturate and flags
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MOD_MAX  = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             EN,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             DIR,
    input  logic             SAT,
    input  logic             FLAG_CLR,
    output logic [WIDTH-1:0] counter,
    output logic             OV,
    output logic             UF,
    output logic             OV_STICKY,
    output logic             UF_STICKY,
    output logic             TC
);

    generate
        if (!`COUNTER_WIDTH_OK(WIDTH)) begin : g_bad_width
            $error("mod_counter: WIDTH must be in 2..32");
        end
        if (!`COUNTER_MOD_MAX_OK(MOD_MAX, WIDTH)) begin : g_bad_mod_max
            $error("mod_counter: MOD_MAX must be >= 1 and fit in WIDTH bits");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_V = MOD_MAX[WIDTH-1:0];

    logic             tick;
    logic [WIDTH-1:0] counter_nxt;
    logic             ov_nxt;
    logic             uf_nxt;

    // LOAD restarts the prescale window as well as CLR, so a load never inherits a partial phase.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .Reset (Reset),
        .EN    (EN),
        .CLR   (CLR | LOAD),
        .tick  (tick)
    );

    // Next count and pulse selection: CLR over LOAD over a prescaled step.
    always_comb begin
        counter_nxt = counter;
        ov_nxt      = 1'b0;
        uf_nxt      = 1'b0;
        if (CLR) begin
            counter_nxt = '0;
        end else if (LOAD) begin
            counter_nxt = (LOAD_VAL > MAX_V) ? MAX_V : LOAD_VAL;
        end else if (tick) begin
            if (DIR == DIR_UP) begin
                if (counter == MAX_V) begin
                    // The pulse marks the attempt to pass MOD_MAX, even when saturating.
                    ov_nxt      = 1'b1;
                    counter_nxt = (SAT == MODE_SAT) ? MAX_V : '0;
                end else begin
                    counter_nxt = counter + WIDTH'(1);
                end
            end else begin
                if (counter == '0) begin
                    uf_nxt      = 1'b1;
                    counter_nxt = (SAT == MODE_SAT) ? '0 : MAX_V;
                end else begin
                    counter_nxt = counter - WIDTH'(1);
                end
            end
        end
    end

    // Count register and the single-cycle OV/UF pulses share one edge.
    always_ff @(posedge clk) begin
        if (Reset) begin
            counter <= '0;
            OV      <= 1'b0;
            UF      <= 1'b0;
        end else begin
            counter <= counter_nxt;
            OV      <= ov_nxt;
            UF      <= uf_nxt;
        end
    end

    // Sticky flags latch the registered pulses; a pulse beats a same-cycle FLAG_CLR.
    always_ff @(posedge clk) begin
        if (Reset) begin
            OV_STICKY <= 1'b0;
            UF_STICKY <= 1'b0;
        end else begin
            if (OV) begin
                OV_STICKY <= 1'b1;
            end else if (FLAG_CLR) begin
                OV_STICKY <= 1'b0;
            end
            if (UF) begin
                UF_STICKY <= 1'b1;
            end else if (FLAG_CLR) begin
                UF_STICKY <= 1'b0;
            end
        end
    end

    // Terminal count follows the current direction combinationally.
    assign TC = (DIR == DIR_UP) ? (counter == MAX_V) : (counter == '0);

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - directed self-checking bench for mod_counter
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       EN = 1'b0;
    logic       CLR = 1'b0;
    logic       LOAD = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       DIR = 1'b1;
    logic       SAT = 1'b0;
    logic       FLAG_CLR = 1'b0;

    logic [7:0] cnt_a, cnt_c;
    logic [3:0] cnt_b;
    logic ov_a, uf_a, ovs_a, ufs_a, tc_a;
    logic ov_b, uf_b, ovs_b, ufs_b, tc_b;
    logic ov_c, uf_c, ovs_c, ufs_c, tc_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // a: full-range 8-bit, b: modulo-10 in 4 bits, c: 8-bit with prescale 4
    mod_counter #(.WIDTH(8)) u_a (
        .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(load_val),
        .DIR(DIR), .SAT(SAT), .FLAG_CLR(FLAG_CLR), .counter(cnt_a), .OV(ov_a), .UF(uf_a),
        .OV_STICKY(ovs_a), .UF_STICKY(ufs_a), .TC(tc_a)
    );

    mod_counter #(.WIDTH(4), .MOD_MAX(9)) u_b (
        .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(load_val[3:0]),
        .DIR(DIR), .SAT(SAT), .FLAG_CLR(FLAG_CLR), .counter(cnt_b), .OV(ov_b), .UF(uf_b),
        .OV_STICKY(ovs_b), .UF_STICKY(ufs_b), .TC(tc_b)
    );

    mod_counter #(.WIDTH(8), .PRESCALE(4)) u_c (
        .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(load_val),
        .DIR(DIR), .SAT(SAT), .FLAG_CLR(FLAG_CLR), .counter(cnt_c), .OV(ov_c), .UF(uf_c),
        .OV_STICKY(ovs_c), .UF_STICKY(ufs_c), .TC(tc_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; EN = 1'b0; CLR = 1'b0; LOAD = 1'b0; DIR = 1'b1; SAT = 1'b0; FLAG_CLR = 1'b0;
        step(); step();
        checks++; if (cnt_a !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0h exp=0", cnt_a); end
        checks++; if ({ov_a, uf_a, ovs_a, ufs_a} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {ov_a, uf_a, ovs_a, ufs_a}); end
        checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL reset_tc_up got=%b exp=0", tc_a); end
        DIR = 1'b0; #1;
        checks++; if (tc_a !== 1'b1) begin failures++; $display("FAIL reset_tc_down got=%b exp=1", tc_a); end
    endtask

    task automatic test_wrap();
        Reset = 1'b0; DIR = 1'b1; SAT = 1'b0; EN = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            step();
            checks++; if (cnt_a !== 8'(i) || ov_a !== 1'b0) begin failures++; $display("FAIL wrap_run i=%0d got=%0h/%b exp=%0h/0", i, cnt_a, ov_a, i); end
        end
        checks++; if (tc_a !== 1'b1) begin failures++; $display("FAIL wrap_tc got=%b exp=1", tc_a); end
        step();
        checks++; if (cnt_a !== 8'd0 || ov_a !== 1'b1 || ovs_a !== 1'b0) begin failures++; $display("FAIL wrap_ov got=%0h/%b/%b exp=0/1/0", cnt_a, ov_a, ovs_a); end
        step();
        checks++; if (cnt_a !== 8'd1 || ov_a !== 1'b0 || ovs_a !== 1'b1) begin failures++; $display("FAIL wrap_sticky got=%0h/%b/%b exp=1/0/1", cnt_a, ov_a, ovs_a); end
        EN = 1'b0;
    endtask

    task automatic test_modulo_load();
        EN = 1'b0; LOAD = 1'b1; load_val = 8'd15; DIR = 1'b1; SAT = 1'b0;
        step();
        checks++; if (cnt_b !== 4'd9 || ov_b !== 1'b0) begin failures++; $display("FAIL load_clamp got=%0d/%b exp=9/0", cnt_b, ov_b); end
        checks++; if (tc_b !== 1'b1) begin failures++; $display("FAIL mod_tc got=%b exp=1", tc_b); end
        LOAD = 1'b0; EN = 1'b1;
        step();
        checks++; if (cnt_b !== 4'd0 || ov_b !== 1'b1) begin failures++; $display("FAIL mod_wrap_up got=%0d/%b exp=0/1", cnt_b, ov_b); end
        DIR = 1'b0;
        step();
        checks++; if (cnt_b !== 4'd9 || uf_b !== 1'b1 || ov_b !== 1'b0) begin failures++; $display("FAIL mod_wrap_down got=%0d/%b/%b exp=9/1/0", cnt_b, uf_b, ov_b); end
        DIR = 1'b1; SAT = 1'b1;
        step();
        checks++; if (cnt_b !== 4'd9 || ov_b !== 1'b1) begin failures++; $display("FAIL mod_sat_up got=%0d/%b exp=9/1", cnt_b, ov_b); end
        EN = 1'b0; SAT = 1'b0;
    endtask

    task automatic test_down_saturate();
        logic [7:0] exp_cnt [4] = '{8'd1, 8'd0, 8'd0, 8'd0};
        logic       exp_uf  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        Reset = 1'b1; step(); Reset = 1'b0;
        SAT = 1'b1; DIR = 1'b0; LOAD = 1'b1; load_val = 8'd2; EN = 1'b1;
        step();
        checks++; if (cnt_a !== 8'd2 || uf_a !== 1'b0) begin failures++; $display("FAIL dsat_load got=%0d/%b exp=2/0", cnt_a, uf_a); end
        LOAD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (cnt_a !== exp_cnt[i] || uf_a !== exp_uf[i]) begin failures++; $display("FAIL dsat_step%0d got=%0d/%b exp=%0d/%b", i, cnt_a, uf_a, exp_cnt[i], exp_uf[i]); end
        end
        EN = 1'b0;
        step();
        checks++; if (cnt_a !== 8'd0 || uf_a !== 1'b0 || ufs_a !== 1'b1) begin failures++; $display("FAIL dsat_sticky got=%0d/%b/%b exp=0/0/1", cnt_a, uf_a, ufs_a); end
        SAT = 1'b0;
    endtask

    task automatic test_prescaler();
        int expv;
        Reset = 1'b1; EN = 1'b0; step(); Reset = 1'b0;
        DIR = 1'b1; SAT = 1'b0; LOAD = 1'b0; CLR = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            EN = (k % 2) == 1;
            step();
            expv = ((k + 1) / 2) / 4;
            checks++; if (cnt_c !== 8'(expv)) begin failures++; $display("FAIL pre_toggle k=%0d got=%0d exp=%0d", k, cnt_c, expv); end
        end
        EN = 1'b1; step(); step();
        CLR = 1'b1;
        step();
        checks++; if (cnt_c !== 8'd0) begin failures++; $display("FAIL pre_clr got=%0d exp=0", cnt_c); end
        CLR = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            step();
            expv = (j == 4) ? 1 : 0;
            checks++; if (cnt_c !== 8'(expv)) begin failures++; $display("FAIL pre_after_clr j=%0d got=%0d exp=%0d", j, cnt_c, expv); end
        end
        step(); step();
        Reset = 1'b1;
        step();
        checks++; if (cnt_c !== 8'd0) begin failures++; $display("FAIL pre_reset got=%0d exp=0", cnt_c); end
        Reset = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            step();
            expv = (j == 4) ? 1 : 0;
            checks++; if (cnt_c !== 8'(expv)) begin failures++; $display("FAIL pre_after_reset j=%0d got=%0d exp=%0d", j, cnt_c, expv); end
        end
        EN = 1'b0;
    endtask

    task automatic test_priority();
        Reset = 1'b1; step(); Reset = 1'b0;
        DIR = 1'b1; SAT = 1'b0;
        LOAD = 1'b1; load_val = 8'd5; EN = 1'b0;
        step();
        CLR = 1'b1; LOAD = 1'b1; EN = 1'b1; load_val = 8'd7;
        step();
        checks++; if (cnt_a !== 8'd0 || ov_a !== 1'b0) begin failures++; $display("FAIL prio_clr_load_en got=%0d/%b exp=0/0", cnt_a, ov_a); end
        CLR = 1'b0;
        step();
        checks++; if (cnt_a !== 8'd7) begin failures++; $display("FAIL prio_load_en got=%0d exp=7", cnt_a); end
        LOAD = 1'b0;
        step();
        checks++; if (cnt_a !== 8'd8) begin failures++; $display("FAIL prio_step_after_load got=%0d exp=8", cnt_a); end
        LOAD = 1'b1; load_val = 8'd255; EN = 1'b0;
        step();
        LOAD = 1'b0; EN = 1'b1;
        step();
        checks++; if (cnt_a !== 8'd0 || ov_a !== 1'b1 || ovs_a !== 1'b0) begin failures++; $display("FAIL prio_ov got=%0d/%b/%b exp=0/1/0", cnt_a, ov_a, ovs_a); end
        EN = 1'b0; FLAG_CLR = 1'b1;
        step();
        checks++; if (ovs_a !== 1'b1 || ov_a !== 1'b0) begin failures++; $display("FAIL prio_set_beats_clr got=%b/%b exp=1/0", ovs_a, ov_a); end
        step();
        checks++; if (ovs_a !== 1'b0) begin failures++; $display("FAIL prio_flag_clr got=%b exp=0", ovs_a); end
        FLAG_CLR = 1'b0;
    endtask

    task automatic test_reset_mid();
        Reset = 1'b1; step(); Reset = 1'b0;
        DIR = 1'b0; SAT = 1'b0; EN = 1'b1;
        step();
        checks++; if (cnt_a !== 8'd255 || uf_a !== 1'b1) begin failures++; $display("FAIL mid_uf got=%0d/%b exp=255/1", cnt_a, uf_a); end
        EN = 1'b0;
        step();
        DIR = 1'b1; EN = 1'b1;
        step();
        LOAD = 1'b1; load_val = 8'h37; EN = 1'b0;
        step();
        checks++; if (cnt_a !== 8'h37 || ovs_a !== 1'b1 || ufs_a !== 1'b1) begin failures++; $display("FAIL mid_setup got=%0h/%b/%b exp=37/1/1", cnt_a, ovs_a, ufs_a); end
        LOAD = 1'b0; Reset = 1'b1; DIR = 1'b1;
        step();
        checks++; if (cnt_a !== 8'd0 || {ov_a, uf_a, ovs_a, ufs_a} !== 4'b0) begin failures++; $display("FAIL mid_reset got=%0h/%b exp=0/0000", cnt_a, {ov_a, uf_a, ovs_a, ufs_a}); end
        checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL mid_tc_up got=%b exp=0", tc_a); end
        DIR = 1'b0; #1;
        checks++; if (tc_a !== 1'b1) begin failures++; $display("FAIL mid_tc_down got=%b exp=1", tc_a); end
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_modulo_load();
        test_down_saturate();
        test_prescaler();
        test_priority();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
